// File: rtl/frame_param_sequencer.sv
// Purpose: counts video frames on a monitored AXI-Stream and, at each frame end, writes the
//          frame counter (reg 0) and a pan accumulator (reg 1) over an AXI-Lite master port.
// Latency: 5 cycles from frame-end edge back to IDLE with a zero-wait slave; back-pressure via
//          awready/wready/bvalid simply stretches ADDR_DATA/RESP, the stream taps are never stalled.
//
// Ports:
//   aclk, aresetn                 clock, asynchronous active-low reset
//   enable                        gate for issuing register updates (counting always runs)
//   pan_step                      increment applied to the pan accumulator per issued update
//   mon_tvalid/tready/tlast/tuser monitor-only stream taps (tuser = start of frame)
//   m_axi_aw*/w*/b*               AXI-Lite write channels towards the generator register file
//   busy                          high while a write sequence is in flight
//   frame_count                   completed frames (wraps)
//   error_count, overrun_count    saturating counts of bad responses / dropped frame ends

module frame_param_sequencer #(
    parameter int          AXI_LITE_ADDR_WIDTH = 8,
    parameter int          LINES_PER_FRAME     = 480,
    parameter int unsigned BASE_ADDR           = 0
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic                           enable,
    input  logic [31:0]                    pan_step,
    input  logic                           mon_tvalid,
    input  logic                           mon_tready,
    input  logic                           mon_tlast,
    input  logic                           mon_tuser,
    output logic [AXI_LITE_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                           m_axi_awvalid,
    input  logic                           m_axi_awready,
    output logic [31:0]                    m_axi_wdata,
    output logic                           m_axi_wvalid,
    input  logic                           m_axi_wready,
    input  logic [1:0]                     m_axi_bresp,
    input  logic                           m_axi_bvalid,
    output logic                           m_axi_bready,
    output logic                           busy,
    output logic [31:0]                    frame_count,
    output logic [15:0]                    error_count,
    output logic [15:0]                    overrun_count
);

    localparam int LCW = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;
    localparam logic [LCW-1:0] LAST_LINE = LCW'(LINES_PER_FRAME - 1);
    localparam logic [AXI_LITE_ADDR_WIDTH-1:0] ADDR_REG0 = AXI_LITE_ADDR_WIDTH'(BASE_ADDR);
    localparam logic [AXI_LITE_ADDR_WIDTH-1:0] ADDR_REG1 = AXI_LITE_ADDR_WIDTH'(BASE_ADDR + 32'd4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR_DATA,
        S_RESP
    } state_t;

    state_t         state;
    logic           idx;
    logic           pending;
    logic [31:0]    pan_acc;
    logic [LCW-1:0] line_cnt;

    logic           beat;
    logic [LCW-1:0] line_base;
    logic           frame_end;
    logic           take_pending;

    // A start-of-frame beat re-aligns the counter before its own tlast is evaluated,
    // so a single-line frame or a truncated previous frame is handled on the same beat.
    always_comb begin
        beat      = mon_tvalid & mon_tready;
        line_base = (beat & mon_tuser) ? '0 : line_cnt;
        frame_end = beat & mon_tlast & (line_base == LAST_LINE);
    end

    assign take_pending = (state == S_IDLE) & pending;

    // Stream monitor: line counter and frame counter.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            line_cnt    <= '0;
            frame_count <= '0;
        end else begin
            if (beat) begin
                if (mon_tlast) begin
                    line_cnt <= frame_end ? '0 : line_base + LCW'(1);
                end else begin
                    line_cnt <= line_base;
                end
            end
            if (frame_end) begin
                frame_count <= frame_count + 32'd1;
            end
        end
    end

    // Pending request flag. A frame end landing on the very edge where IDLE consumes
    // the flag is not an overrun: the old request is leaving and the new one takes its place.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pending       <= 1'b0;
            overrun_count <= '0;
        end else begin
            if (frame_end && enable) begin
                if (pending && !take_pending && overrun_count != 16'hFFFF) begin
                    overrun_count <= overrun_count + 16'd1;
                end
                pending <= 1'b1;
            end else if (take_pending) begin
                pending <= 1'b0;
            end
        end
    end

    // Write sequencer: two back-to-back AXI-Lite writes per request.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= S_IDLE;
            idx           <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            busy          <= 1'b0;
            pan_acc       <= '0;
            error_count   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pending) begin
                        idx           <= 1'b0;
                        m_axi_awaddr  <= ADDR_REG0;
                        m_axi_wdata   <= frame_count;
                        m_axi_awvalid <= 1'b1;
                        m_axi_wvalid  <= 1'b1;
                        busy          <= 1'b1;
                        state         <= S_ADDR_DATA;
                    end
                end

                S_ADDR_DATA: begin
                    // AW and W retire independently; address/data registers are untouched
                    // here so they stay stable while their valid is held.
                    if (m_axi_awvalid && m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                    end
                    if (m_axi_wvalid && m_axi_wready) begin
                        m_axi_wvalid <= 1'b0;
                    end
                    if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
                        m_axi_bready <= 1'b1;
                        state        <= S_RESP;
                    end
                end

                S_RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        if (m_axi_bresp != 2'b00 && error_count != 16'hFFFF) begin
                            error_count <= error_count + 16'd1;
                        end
                        // An error on reg 0 does not cancel the reg 1 write.
                        if (!idx) begin
                            idx           <= 1'b1;
                            m_axi_awaddr  <= ADDR_REG1;
                            m_axi_wdata   <= pan_acc + pan_step;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state         <= S_ADDR_DATA;
                        end else begin
                            pan_acc <= pan_acc + pan_step;
                            busy    <= 1'b0;
                            state   <= S_IDLE;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_param_sequencer.sv
// Purpose: self-checking bench for frame_param_sequencer (LINES_PER_FRAME=4, pan_step=5).
// Latency: checks the 5-cycle frame-end-to-IDLE path with a zero-wait slave model.
// Backpressure: slave model applies per-channel AW/W/B delays and programmable bresp.

module tb_frame_param_sequencer;

    logic        aclk;
    logic        aresetn;
    logic        enable;
    logic [31:0] pan_step;
    logic        mon_tvalid, mon_tready, mon_tlast, mon_tuser;
    logic [7:0]  m_axi_awaddr;
    logic        m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic        m_axi_wvalid, m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid, m_axi_bready;
    logic        busy;
    logic [31:0] frame_count;
    logic [15:0] error_count, overrun_count;

    frame_param_sequencer #(
        .AXI_LITE_ADDR_WIDTH (8),
        .LINES_PER_FRAME     (4),
        .BASE_ADDR           (0)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .enable        (enable),
        .pan_step      (pan_step),
        .mon_tvalid    (mon_tvalid),
        .mon_tready    (mon_tready),
        .mon_tlast     (mon_tlast),
        .mon_tuser     (mon_tuser),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .busy          (busy),
        .frame_count   (frame_count),
        .error_count   (error_count),
        .overrun_count (overrun_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // ---------------- slave model (acts on falling edges) ----------------
    int          aw_dly, w_dly, b_dly;
    logic [1:0]  resp0, resp1;
    logic        aw_fire, w_fire, b_fire, aw_got, w_got, b_arm;
    int          aw_wait, w_wait, b_wait;
    logic [7:0]  cap_addr;
    logic [31:0] cap_data;
    logic [7:0]  log_addr [0:31];
    logic [31:0] log_data [0:31];
    int          log_n = 0;

    always @(negedge aclk) begin
        if (!aresetn) begin
            m_axi_awready = 1'b0;
            m_axi_wready  = 1'b0;
            m_axi_bvalid  = 1'b0;
            m_axi_bresp   = 2'b00;
            aw_fire = 1'b0; w_fire = 1'b0; b_fire = 1'b0;
            aw_got  = 1'b0; w_got  = 1'b0; b_arm  = 1'b0;
            aw_wait = 0; w_wait = 0; b_wait = 0;
        end else begin
            if (b_fire) m_axi_bvalid = 1'b0;
            if (aw_fire) begin aw_got = 1'b1; aw_wait = 0; end
            if (w_fire)  begin w_got  = 1'b1; w_wait  = 0; end
            if (aw_got && w_got) begin
                if (log_n < 32) begin
                    log_addr[log_n] = cap_addr;
                    log_data[log_n] = cap_data;
                end
                log_n++;
                aw_got = 1'b0; w_got = 1'b0;
                b_wait = 0; b_arm = 1'b1;
                m_axi_bresp = (cap_addr == 8'h04) ? resp1 : resp0;
            end
            if (b_arm) begin
                if (b_wait >= b_dly) begin m_axi_bvalid = 1'b1; b_arm = 1'b0; end
                else b_wait++;
            end
            m_axi_awready = m_axi_awvalid && !aw_got && (aw_wait >= aw_dly);
            if (m_axi_awvalid && !aw_got && !m_axi_awready) aw_wait++;
            m_axi_wready = m_axi_wvalid && !w_got && (w_wait >= w_dly);
            if (m_axi_wvalid && !w_got && !m_axi_wready) w_wait++;
            aw_fire = m_axi_awvalid && m_axi_awready;
            w_fire  = m_axi_wvalid && m_axi_wready;
            b_fire  = m_axi_bvalid && m_axi_bready;
            if (aw_fire) cap_addr = m_axi_awaddr;
            if (w_fire)  cap_data = m_axi_wdata;
        end
    end

    // ---------------- checking helpers ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic cfg_slave(input int a, input int w, input int b,
                             input logic [1:0] r0, input logic [1:0] r1);
        aw_dly = a; w_dly = w; b_dly = b; resp0 = r0; resp1 = r1;
    endtask

    // Four lines; the last beat of line 1 is first offered with tready low (not a beat).
    task automatic send_frame(input int bpl);
        for (int l = 0; l < 4; l++) begin
            for (int b = 0; b < bpl; b++) begin
                @(negedge aclk);
                mon_tvalid = 1'b1;
                mon_tuser  = (l == 0 && b == 0);
                mon_tlast  = (b == bpl - 1);
                mon_tready = !(l == 1 && b == bpl - 1);
                if (!mon_tready) begin
                    @(negedge aclk);
                    mon_tready = 1'b1;
                end
            end
        end
        @(negedge aclk);
        mon_tvalid = 1'b0; mon_tuser = 1'b0; mon_tlast = 1'b0;
    endtask

    // Returns the number of falling edges (after the frame-end edge) until busy falls, or -1.
    task automatic wait_idle(output int lat);
        logic seen;
        seen = 1'b0;
        lat  = -1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge aclk);
            if (busy) seen = 1'b1;
            else if (seen) begin lat = k; break; end
        end
    endtask

    typedef struct {
        logic        en;
        int          aw_d, w_d, b_d;
        logic [1:0]  r0, r1;
        int          nw;
        logic [7:0]  a0;
        logic [31:0] d0;
        logic [7:0]  a1;
        logic [31:0] d1;
        logic [31:0] fc;
        logic [15:0] err;
    } vec_t;

    vec_t vecs [7];
    int   base, lat;

    initial begin
        aresetn = 1'b0; enable = 1'b0; pan_step = 32'd5;
        mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0; mon_tuser = 1'b0;
        cfg_slave(0, 0, 0, 2'b00, 2'b00);

        //            en    aw w  b  r0     r1     nw a0     d0     a1     d1      fc     err
        vecs[0] = '{1'b1, 0, 0, 0, 2'b00, 2'b00, 2, 8'h00, 32'd1, 8'h04, 32'd5,  32'd1, 16'd0};
        vecs[1] = '{1'b1, 0, 0, 0, 2'b00, 2'b00, 2, 8'h00, 32'd2, 8'h04, 32'd10, 32'd2, 16'd0};
        vecs[2] = '{1'b1, 3, 0, 0, 2'b00, 2'b00, 2, 8'h00, 32'd3, 8'h04, 32'd15, 32'd3, 16'd0};
        vecs[3] = '{1'b1, 0, 0, 0, 2'b10, 2'b00, 2, 8'h00, 32'd4, 8'h04, 32'd20, 32'd4, 16'd1};
        vecs[4] = '{1'b0, 0, 0, 0, 2'b00, 2'b00, 0, 8'h00, 32'd0, 8'h00, 32'd0,  32'd5, 16'd1};
        vecs[5] = '{1'b1, 0, 2, 2, 2'b00, 2'b00, 2, 8'h00, 32'd6, 8'h04, 32'd25, 32'd6, 16'd1};
        vecs[6] = '{1'b1, 0, 0, 0, 2'b11, 2'b11, 2, 8'h00, 32'd7, 8'h04, 32'd30, 32'd7, 16'd3};

        repeat (3) @(negedge aclk);
        check("rst_ctrl", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy}, 4'b0000);
        check("rst_frame_count", frame_count, 32'd0);
        check("rst_error_count", error_count, 16'd0);
        check("rst_overrun_count", overrun_count, 16'd0);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        // ---------------- table-driven frames ----------------
        for (int i = 0; i < 7; i++) begin
            cfg_slave(vecs[i].aw_d, vecs[i].w_d, vecs[i].b_d, vecs[i].r0, vecs[i].r1);
            enable = vecs[i].en;
            base   = log_n;
            send_frame(3);
            if (vecs[i].en) begin
                wait_idle(lat);
                if (vecs[i].aw_d == 0 && vecs[i].w_d == 0 && vecs[i].b_d == 0)
                    check($sformatf("v%0d_latency", i), 64'(lat), 64'd5);
                else
                    check($sformatf("v%0d_completed", i), 64'(lat > 0), 64'd1);
            end else begin
                repeat (10) @(negedge aclk);
            end
            repeat (2) @(negedge aclk);
            check($sformatf("v%0d_nwrites", i), 64'(log_n - base), 64'(vecs[i].nw));
            if (vecs[i].nw == 2) begin
                check($sformatf("v%0d_wr0", i), {log_addr[base], log_data[base]},
                      {vecs[i].a0, vecs[i].d0});
                check($sformatf("v%0d_wr1", i), {log_addr[base+1], log_data[base+1]},
                      {vecs[i].a1, vecs[i].d1});
            end
            check($sformatf("v%0d_frame_count", i), frame_count, vecs[i].fc);
            check($sformatf("v%0d_error_count", i), error_count, vecs[i].err);
            check($sformatf("v%0d_overrun", i), overrun_count, 16'd0);
            check($sformatf("v%0d_busy", i), busy, 1'b0);
        end

        // ---------------- AW delayed 3 cycles, W immediate ----------------
        cfg_slave(3, 0, 0, 2'b00, 2'b00);
        enable = 1'b1;
        base   = log_n;
        send_frame(3);
        @(negedge aclk);
        check("awdly_k1", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_awaddr}, {3'b110, 8'h00});
        for (int k = 2; k <= 4; k++) begin
            @(negedge aclk);
            check($sformatf("awdly_k%0d", k),
                  {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_awaddr}, {3'b100, 8'h00});
        end
        @(negedge aclk);
        check("awdly_k5", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_awaddr}, {3'b001, 8'h00});
        wait_idle(lat);
        check("awdly_completed", 64'(lat > 0), 64'd1);
        check("awdly_wr0", {log_addr[base], log_data[base]}, {8'h00, 32'd8});
        check("awdly_wr1", {log_addr[base+1], log_data[base+1]}, {8'h04, 32'd35});

        // ---------------- B stalled 20 cycles while two more frames end ----------------
        aresetn = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        cfg_slave(0, 0, 20, 2'b00, 2'b00);
        base = log_n;
        send_frame(1);
        send_frame(1);
        send_frame(1);
        for (int k = 0; k < 400 && (log_n - base) < 4; k++) @(negedge aclk);
        wait_idle(lat);
        repeat (6) @(negedge aclk);
        check("stall_nwrites", 64'(log_n - base), 64'd4);
        check("stall_wr0", {log_addr[base],   log_data[base]},   {8'h00, 32'd1});
        check("stall_wr1", {log_addr[base+1], log_data[base+1]}, {8'h04, 32'd5});
        check("stall_wr2", {log_addr[base+2], log_data[base+2]}, {8'h00, 32'd3});
        check("stall_wr3", {log_addr[base+3], log_data[base+3]}, {8'h04, 32'd10});
        check("stall_frame_count", frame_count, 32'd3);
        check("stall_overrun", overrun_count, 16'd1);
        check("stall_busy", busy, 1'b0);

        // ---------------- reset asserted during ADDR_DATA ----------------
        cfg_slave(10, 0, 0, 2'b00, 2'b00);
        base = log_n;
        send_frame(1);
        repeat (2) @(negedge aclk);
        check("pre_rst_state", {m_axi_awvalid, busy, frame_count, overrun_count},
              {2'b11, 32'd4, 16'd1});
        #1 aresetn = 1'b0;
        #1;
        check("midrst_ctrl", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy}, 4'b0000);
        check("midrst_counts", {frame_count, error_count, overrun_count}, 64'd0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        repeat (10) @(negedge aclk);
        check("post_rst_quiet", {busy, m_axi_awvalid, 8'(log_n - base)}, 10'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
